// File: rtl/i2c_init_sequencer.sv
// Boot-time I2C register loader: walks a parameter table of {reg,data} writes and drives
// one i2c_master over its valid/ready/error handshake, with per-entry retry and inter-command gap.
module i2c_init_sequencer #(
  parameter int                    N_CMDS      = 10,
  parameter logic [N_CMDS*16-1:0]  INIT_TABLE  = '0,
  parameter logic [6:0]            DEV_ADDR    = 7'h1A,
  parameter int                    MAX_RETRIES = 3,
  parameter int                    GAP_CYCLES  = 4,
  parameter bit                    AUTO_START  = 1'b1,
  localparam int                   IW          = $clog2(N_CMDS + 1),
  localparam int                   RW          = $clog2(MAX_RETRIES + 1)
) (
  input  logic          i2c_clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [IW-1:0] cmd_index,
  output logic [RW-1:0] retry_cnt,
  output logic [6:0]    slav_addr,
  output logic          read_not_write,
  output logic [7:0]    reg_addr,
  output logic [7:0]    write_data,
  output logic          write_valid,
  input  logic          write_ready,
  input  logic          error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REQ, S_BUSY, S_FINISH, S_GAP, S_DONE, S_FAIL
  } state_t;

  localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int              GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [IW-1:0]   LAST_IDX = IW'(N_CMDS - 1);
  localparam logic [RW-1:0]   MAX_CNT  = RW'(MAX_RETRIES);
  localparam state_t          S_AFTER  = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;

  state_t        r_state, w_next;
  logic [IW-1:0] r_cmd_index;
  logic [RW-1:0] r_retry_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic [7:0]    r_reg_addr, r_write_data;

  logic [15:0]   w_entry;
  logic [RW-1:0] w_retry_next;
  logic          w_nack, w_launch, w_cmd_inc, w_retry_inc, w_retry_clr;

  assign w_entry      = INIT_TABLE[{r_cmd_index, 4'b0000} +: 16];
  assign w_retry_next = r_retry_cnt + RW'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    w_next      = r_state;
    w_launch    = 1'b0;
    w_cmd_inc   = 1'b0;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    // An X/Z error fails the equality test and is therefore taken as a NACK.
    w_nack      = 1'b1;
    if (error == 1'b0) w_nack = 1'b0;

    case (r_state)
      S_IDLE:   if (start || AUTO_START) begin
                  w_next   = S_LOAD;
                  w_launch = 1'b1;
                end
      S_LOAD:   w_next = S_REQ;
      S_REQ:    if (write_ready) w_next = S_BUSY;
      S_BUSY:   if (!write_ready) w_next = S_FINISH;
      S_FINISH: if (write_ready) begin
                  if (!w_nack) begin
                    w_retry_clr = 1'b1;
                    if (r_cmd_index == LAST_IDX) begin
                      w_next = S_DONE;
                    end else begin
                      w_cmd_inc = 1'b1;
                      w_next    = S_AFTER;
                    end
                  end else begin
                    w_retry_inc = 1'b1;
                    w_next      = (w_retry_next == MAX_CNT) ? S_FAIL : S_AFTER;
                  end
                end
      S_GAP:    if (r_gap_cnt == GW'(GAP_LAST)) w_next = S_LOAD;
      S_DONE,
      S_FAIL:   if (start) begin
                  w_next   = S_LOAD;
                  w_launch = 1'b1;
                end
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: state-holding processes use non-blocking assignments so all registers update together.
  always_ff @(posedge i2c_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge i2c_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_index  <= '0;
      r_retry_cnt  <= '0;
      r_gap_cnt    <= '0;
      r_reg_addr   <= '0;
      r_write_data <= '0;
    end else begin
      if (w_launch) begin
        r_cmd_index <= '0;
        r_retry_cnt <= '0;
      end else begin
        if (w_cmd_inc)        r_cmd_index <= r_cmd_index + IW'(1);
        if (w_retry_clr)      r_retry_cnt <= '0;
        else if (w_retry_inc) r_retry_cnt <= w_retry_next;
      end

      // Command fields are latched once per attempt and held steady through the transfer.
      if (r_state == S_LOAD) begin
        r_reg_addr   <= w_entry[15:8];
        r_write_data <= w_entry[7:0];
      end

      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + GW'(1);
      else                  r_gap_cnt <= '0;
    end
  end

  assign busy           = !(r_state inside {S_IDLE, S_DONE, S_FAIL});
  assign done           = (r_state == S_DONE);
  assign fail           = (r_state == S_FAIL);
  assign write_valid    = (r_state == S_REQ);
  assign cmd_index      = r_cmd_index;
  assign retry_cnt      = r_retry_cnt;
  assign slav_addr      = DEV_ADDR;
  assign read_not_write = 1'b0;
  assign reg_addr       = r_reg_addr;
  assign write_data     = r_write_data;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: randomized master model plus a transaction-level reference
// model of which entry/attempt must be requested next and what the final status must be.
module tb_i2c_init_sequencer;

  localparam int N    = 3;
  localparam int MAXR = 3;
  localparam int GAP  = 4;
  localparam logic [6:0] R0 = 7'h05, R1 = 7'h22, R2 = 7'h7F;
  localparam logic [8:0] D0 = 9'h1A3, D1 = 9'h0FF, D2 = 9'h100;
  localparam logic [N*16-1:0] TABLE = {R2, D2, R1, D1, R0, D0};

  typedef enum int {M_IDLE, M_ACC, M_LOW, M_HIGH} mphase_t;

  logic       i2c_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_main = 1'b0, start_rand = 1'b0, start;
  logic       write_ready, error;
  logic       busy, done, fail, read_not_write, write_valid;
  logic [1:0] cmd_index, retry_cnt;
  logic [6:0] slav_addr;
  logic [7:0] reg_addr, write_data;

  logic       start0 = 1'b0, s0_ready;
  logic       s0_busy, s0_done, s0_fail, s0_rnw, s0_write_valid;
  logic [1:0] s0_cmd_index, s0_retry_cnt;
  logic [6:0] s0_slav_addr;
  logic [7:0] s0_reg_addr, s0_write_data;

  assign start = start_main | start_rand;

  i2c_init_sequencer #(.N_CMDS(N), .INIT_TABLE(TABLE), .DEV_ADDR(7'h1A), .MAX_RETRIES(MAXR),
                       .GAP_CYCLES(GAP), .AUTO_START(1'b1)) dut (
    .i2c_clk(i2c_clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
    .cmd_index(cmd_index), .retry_cnt(retry_cnt), .slav_addr(slav_addr),
    .read_not_write(read_not_write), .reg_addr(reg_addr), .write_data(write_data),
    .write_valid(write_valid), .write_ready(write_ready), .error(error));

  i2c_init_sequencer #(.N_CMDS(N), .INIT_TABLE(TABLE), .DEV_ADDR(7'h1A), .MAX_RETRIES(MAXR),
                       .GAP_CYCLES(0), .AUTO_START(1'b0)) dut0 (
    .i2c_clk(i2c_clk), .rst_n(rst_n), .start(start0), .busy(s0_busy), .done(s0_done),
    .fail(s0_fail), .cmd_index(s0_cmd_index), .retry_cnt(s0_retry_cnt),
    .slav_addr(s0_slav_addr), .read_not_write(s0_rnw), .reg_addr(s0_reg_addr),
    .write_data(s0_write_data), .write_valid(s0_write_valid), .write_ready(s0_ready),
    .error(1'b0));

  always #5 i2c_clk = ~i2c_clk;

  int n_total = 0, n_bad = 0, cyc = 0;
  // Stimulus configuration (written by the main block only)
  int mode = 0, len_lo = 10, len_hi = 10;
  bit noise_en = 1'b1;
  // Reference model (written by the master process only)
  mphase_t m_phase = M_IDLE;
  int m_idx = 0, m_retry = 0, m_cnt = 0, n_xfer = 0;
  bit m_done = 1'b0, m_fail = 1'b0, m_nack = 1'b0;
  logic [15:0] cap_q[$];
  int rise_q[$], rise0_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_reg(input int i);
    logic [6:0] r;
    logic [8:0] d;
    case (i)
      0:       begin r = R0; d = D0; end
      1:       begin r = R1; d = D1; end
      default: begin r = R2; d = D2; end
    endcase
    return {r, d[8]};
  endfunction

  function automatic logic [7:0] exp_wd(input int i);
    logic [8:0] d;
    case (i)
      0:       d = D0;
      1:       d = D1;
      default: d = D2;
    endcase
    return d[7:0];
  endfunction

  function automatic bit nack_rule(input int mo, input int idx, input int rty);
    case (mo)
      1:       return (idx == 1) && (rty == 0);
      2:       return (idx == 2);
      3:       return ($urandom_range(0, 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  initial forever begin
    @(posedge i2c_clk);
    cyc++;
  end

  // Master model for dut and owner of the reference model; acts on falling edges.
  initial begin
    write_ready = 1'b1;
    error       = 1'b0;
    forever begin
      @(negedge i2c_clk);
      start_rand = 1'b0;
      if (!rst_n) begin
        write_ready = 1'b1;
        error       = 1'b0;
        m_phase     = M_IDLE;
        m_idx = 0; m_retry = 0; m_done = 1'b0; m_fail = 1'b0;
      end else begin
        if (noise_en) error = 1'($urandom_range(0, 1));
        if (start_main && (m_done || m_fail)) begin
          m_idx = 0; m_retry = 0; m_done = 1'b0; m_fail = 1'b0;
        end
        case (m_phase)
          M_IDLE: if (write_valid && write_ready) begin
                    cap_q.push_back({reg_addr, write_data});
                    n_xfer++;
                    m_phase = M_ACC;
                  end
          M_ACC:  begin
                    write_ready = 1'b0;
                    m_cnt       = int'($urandom_range(len_lo, len_hi)) - 1;
                    m_phase     = M_LOW;
                  end
          M_LOW:  if (m_cnt == 0) begin
                    m_nack      = nack_rule(mode, m_idx, m_retry);
                    write_ready = 1'b1;
                    error       = m_nack;
                    m_phase     = M_HIGH;
                  end else begin
                    m_cnt--;
                    if (noise_en && $urandom_range(0, 3) == 0) start_rand = 1'b1;
                  end
          M_HIGH: begin
                    if (!m_nack) begin
                      m_retry = 0;
                      if (m_idx == N - 1) m_done = 1'b1;
                      else                m_idx++;
                    end else begin
                      m_retry++;
                      if (m_retry == MAXR) m_fail = 1'b1;
                    end
                    m_phase = M_IDLE;
                  end
          default: m_phase = M_IDLE;
        endcase
      end
    end
  end

  // Fixed-latency master for dut0: ready low for 2 clocks per transfer, never NACKs.
  initial begin
    int p0 = 0, c0 = 0;
    s0_ready = 1'b1;
    forever begin
      @(negedge i2c_clk);
      if (!rst_n) begin
        s0_ready = 1'b1;
        p0 = 0;
      end else begin
        case (p0)
          0: if (s0_write_valid) p0 = 1;
          1: begin s0_ready = 1'b0; c0 = 1; p0 = 2; end
          2: if (c0 == 0) begin s0_ready = 1'b1; p0 = 3; end else c0--;
          default: p0 = 0;
        endcase
      end
    end
  end

  // Compare process: every request cycle and every settled cycle against the model.
  initial begin
    bit prev_wv = 1'b0, prev_wv0 = 1'b0;
    forever begin
      @(negedge i2c_clk);
      if (rst_n) begin
        if (write_valid) begin
          check("req_reg_addr",   reg_addr,       exp_reg(m_idx));
          check("req_write_data", write_data,     exp_wd(m_idx));
          check("req_cmd_index",  cmd_index,      m_idx);
          check("req_retry_cnt",  retry_cnt,      m_retry);
          check("req_slav_addr",  slav_addr,      7'h1A);
          check("req_rnw",        read_not_write, 1'b0);
          check("req_busy",       busy,           1'b1);
          if (!prev_wv) rise_q.push_back(cyc);
        end
        if ((m_done || m_fail) && m_phase == M_IDLE) begin
          check("idle_done",  done,        m_done);
          check("idle_fail",  fail,        m_fail);
          check("idle_busy",  busy,        1'b0);
          check("idle_valid", write_valid, 1'b0);
        end
        if (s0_write_valid && !prev_wv0) rise0_q.push_back(cyc);
        prev_wv  = write_valid;
        prev_wv0 = s0_write_valid;
      end else begin
        prev_wv  = 1'b0;
        prev_wv0 = 1'b0;
      end
    end
  end

  task automatic pulse_start(input bit en_main, input bit en0);
    @(posedge i2c_clk);
    #2;
    start_main = en_main;
    start0     = en0;
    @(posedge i2c_clk);
    #2;
    start_main = 1'b0;
    start0     = 1'b0;
  endtask

  task automatic wait_settled(input int maxc);
    int k = 0;
    bit settled = 1'b0;
    while (!settled && k < maxc) begin
      @(posedge i2c_clk);
      k++;
      settled = (m_done || m_fail) && (m_phase == M_IDLE);
    end
    check("settle_in_budget", settled, 1'b1);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_done"},      done,      m_done);
    check({tag, "_fail"},      fail,      m_fail);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_cmd_index"}, cmd_index, m_idx);
    check({tag, "_retry_cnt"}, retry_cnt, m_retry);
  endtask

  initial begin
    int xb, cb, rb, r0b, k;
    bit hit;
    // Reset state
    repeat (2) @(posedge i2c_clk);
    #1;
    check("rst_busy", busy, 1'b0);          check("rst_done", done, 1'b0);
    check("rst_fail", fail, 1'b0);          check("rst_valid", write_valid, 1'b0);
    check("rst_cmd_index", cmd_index, 2'd0); check("rst_retry", retry_cnt, 2'd0);
    check("rst_reg_addr", reg_addr, 8'h00); check("rst_wdata", write_data, 8'h00);
    @(posedge i2c_clk);
    #2 rst_n = 1'b1;

    // 1: clean run, 10-clock transfers, random ignored start pulses and error noise
    xb = n_xfer; cb = cap_q.size();
    wait_settled(3000);
    check_status("clean");
    check("clean_done_lit", done, 1'b1);
    check("clean_idx_lit", cmd_index, 2'd2);
    check("clean_xfers", n_xfer - xb, 3);
    check("clean_first", cap_q[cb], 16'h0BA3);
    check("clean_second", cap_q[cb + 1], 16'h44FF);
    check("clean_third", cap_q[cb + 2], 16'hFF00);
    check("s0_stays_idle", {s0_busy, s0_done, s0_fail}, 3'b000);

    // 2: entry 1 NACKed once
    mode = 1; xb = n_xfer; cb = cap_q.size();
    pulse_start(1'b1, 1'b0);
    wait_settled(3000);
    check_status("nack1");
    check("nack1_xfers", n_xfer - xb, 4);
    check("nack1_resend", cap_q[cb + 2], 16'h44FF);

    // 3: entry 2 NACKed always
    mode = 2; xb = n_xfer;
    pulse_start(1'b1, 1'b0);
    wait_settled(3000);
    check_status("nack2");
    check("nack2_fail_lit", fail, 1'b1);
    check("nack2_retry_lit", retry_cnt, 2'd3);
    check("nack2_xfers", n_xfer - xb, 5);

    // 4: restart from FAIL with NACK removed
    mode = 0; xb = n_xfer;
    pulse_start(1'b1, 1'b0);
    wait_settled(3000);
    check_status("rerun");
    check("rerun_xfers", n_xfer - xb, 3);

    // 5: asynchronous reset while entry 1 is in flight
    noise_en = 1'b0;
    pulse_start(1'b1, 1'b0);
    k = 0; hit = 1'b0;
    while (!hit && k < 2000) begin
      @(posedge i2c_clk);
      k++;
      hit = (m_idx == 1) && (m_phase == M_ACC);
    end
    check("reach_entry1_busy", hit, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", write_valid, 1'b0);  check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);          check("arst_fail", fail, 1'b0);
    check("arst_cmd_index", cmd_index, 2'd0); check("arst_retry", retry_cnt, 2'd0);
    check("arst_reg_addr", reg_addr, 8'h00); check("arst_wdata", write_data, 8'h00);
    repeat (3) @(posedge i2c_clk);
    #2 rst_n = 1'b1;
    xb = n_xfer; cb = cap_q.size();
    wait_settled(3000);
    check_status("post_rst");
    check("post_rst_first", cap_q[cb], 16'h0BA3);
    check("post_rst_xfers", n_xfer - xb, 3);

    // 6: request spacing with GAP=4 vs GAP=0, both with 2-clock transfers
    len_lo = 2; len_hi = 2; rb = rise_q.size(); r0b = rise0_q.size();
    pulse_start(1'b1, 1'b1);
    wait_settled(3000);
    check("s0_done", s0_done, 1'b1);
    check("s0_cmd_index", s0_cmd_index, 2'd2);
    check("gap4_space_a", rise_q[rb + 1] - rise_q[rb], 2 + 3 + GAP);
    check("gap4_space_b", rise_q[rb + 2] - rise_q[rb + 1], 2 + 3 + GAP);
    check("gap0_space_a", rise0_q[r0b + 1] - rise0_q[r0b], 5);
    check("gap0_space_b", rise0_q[r0b + 2] - rise0_q[r0b + 1], 5);
    check("gap_diff", (rise_q[rb + 1] - rise_q[rb]) - (rise0_q[r0b + 1] - rise0_q[r0b]), 4);

    // 7: randomized NACKs, transfer lengths, stray starts and error noise
    mode = 3; len_lo = 1; len_hi = 12; noise_en = 1'b1;
    for (int run = 0; run < 12; run++) begin
      pulse_start(1'b1, 1'b0);
      wait_settled(4000);
      check_status("rand");
      check("rand_one_status", done ^ fail, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule
